pc_unit: RTL and testbench

//  Program-counter stage directly upstream of instruction fetch; drives the word-aligned pc that fetch uses to address prgrom.

---
 rtl/pc_unit.sv | 99 +++++++++
 tb/tb_pc_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with reset-vector hold, ROM warm-up and prioritised redirects
module pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          INIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kickOff,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inited,
  output logic        redirect
);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  localparam logic [7:0]  WARM_LAST  = 8'(INIT_CYCLES - 1);
  localparam logic [31:0] ALIGN_MASK = ~32'd3;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] pc_nxt;
  logic        redirect_nxt, inited_nxt;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_nxt       = RESET_PC;
    redirect_nxt = 1'b0;
    inited_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 8'd0;
        if (kickOff) state_nxt = WARMUP;
      end
      WARMUP: begin
        if (!kickOff) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (cnt == WARM_LAST) begin
          state_nxt  = RUN;
          cnt_nxt    = 8'd0;
          inited_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RUN: begin
        if (!kickOff) begin
          state_nxt = IDLE;
        end else begin
          inited_nxt = 1'b1;
          // Stall drops any concurrent redirect; nothing is remembered for later.
          if (stall) begin
            pc_nxt = pc;
          end else if (jr) begin
            pc_nxt       = jr_target & ALIGN_MASK;
            redirect_nxt = 1'b1;
          end else if (jump) begin
            pc_nxt       = jump_target & ALIGN_MASK;
            redirect_nxt = 1'b1;
          end else if (branch_taken) begin
            pc_nxt       = branch_target & ALIGN_MASK;
            redirect_nxt = 1'b1;
          end else begin
            pc_nxt = pc_plus4;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      pc       <= RESET_PC;
      redirect <= 1'b0;
      inited   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pc       <= pc_nxt;
      redirect <= redirect_nxt;
      inited   <= inited_nxt;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed scoreboard bench for pc_unit
module tb_pc_unit;

  localparam int INIT = 4;

  logic        clk = 1'b0;
  logic        rst, kickOff, stall, branch_taken, jump, jr;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] pc, pc_plus4;
  logic        inited, redirect;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        red;
    logic        ini;
    string       tag;
  } exp_t;
  exp_t q[$];

  // reference model: 0 idle, 1 warmup, 2 run
  int          m_state = 0;
  int          m_cnt   = 0;
  logic [31:0] m_pc    = 32'h0;
  logic        m_red   = 1'b0;
  logic        m_ini   = 1'b0;

  always #5 clk = ~clk;

  pc_unit #(.RESET_PC(32'h0), .INIT_CYCLES(INIT)) dut (
    .clk(clk), .rst(rst), .kickOff(kickOff), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .inited(inited), .redirect(redirect)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_pc = 32'h0; m_red = 1'b0; m_ini = 1'b0;
  endtask

  task automatic model_edge();
    m_red = 1'b0;
    if (!kickOff) begin
      m_state = 0; m_cnt = 0; m_pc = 32'h0; m_ini = 1'b0;
    end else if (m_state == 0) begin
      m_state = 1; m_cnt = 0; m_ini = 1'b0;
    end else if (m_state == 1) begin
      if (m_cnt == INIT - 1) begin m_state = 2; m_ini = 1'b1; end
      else m_cnt++;
    end else begin
      m_ini = 1'b1;
      if (stall) ;
      else if (jr)           begin m_pc = {jr_target[31:2], 2'b00};     m_red = 1'b1; end
      else if (jump)         begin m_pc = {jump_target[31:2], 2'b00};   m_red = 1'b1; end
      else if (branch_taken) begin m_pc = {branch_target[31:2], 2'b00}; m_red = 1'b1; end
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic set_in(input logic k, input logic s, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic r, input logic [31:0] rt);
    kickOff = k; stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; jr = r; jr_target = rt;
  endtask

  task automatic step(input string tag);
    exp_t e, o;
    model_edge();
    e.pc = m_pc; e.red = m_red; e.ini = m_ini; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
    o = q.pop_front();
    chk({o.tag, "_pc"},    pc,                 o.pc);
    chk({o.tag, "_p4"},    pc_plus4,           o.pc + 32'd4);
    chk({o.tag, "_red"},   {31'd0, redirect},  {31'd0, o.red});
    chk({o.tag, "_init"},  {31'd0, inited},    {31'd0, o.ini});
    @(negedge clk);
  endtask

  task automatic seq(input string tag);
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(tag);
  endtask

  initial begin
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("reset_pc",   pc,                32'h0);
    chk("reset_p4",   pc_plus4,          32'h4);
    chk("reset_init", {31'd0, inited},   32'h0);
    chk("reset_red",  {31'd0, redirect}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    model_reset();
    step("idle_hold");

    // 1: warm-up, then sequential fetch
    for (int i = 0; i < INIT + 1; i++) seq($sformatf("warm%0d", i));
    chk("warm_inited", {31'd0, inited}, 32'h1);
    chk("warm_pc0",    pc,              32'h0);
    seq("seq4");
    chk("seq4_abs", pc, 32'h4);
    seq("seq8");
    chk("seq8_abs", pc, 32'h8);

    // 2: all redirects together, jr wins
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0);
    step("to_10");
    set_in(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h80, 1'b1, 32'h40);
    step("prio_jr");
    chk("prio_abs", pc, 32'h40);
    seq("after_jr");
    chk("after_jr_abs", pc, 32'h44);

    // 3: stall swallows branch
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0);
    step("to_20");
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
      step($sformatf("stall%0d", i));
    end
    seq("post_stall");
    chk("post_stall_abs", pc, 32'h24);

    // jump beats branch, misaligned branch target masked
    set_in(1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h1F3, 1'b0, 32'h0);
    step("prio_jump");
    set_in(1'b1, 1'b0, 1'b1, 32'h307, 1'b0, 32'h0, 1'b0, 32'h0);
    step("br_mask");

    // 4: wrap at top of address space
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step("to_top");
    chk("top_abs", pc, 32'hFFFF_FFFC);
    seq("wrap");
    chk("wrap_abs", pc, 32'h0);

    // 5: kickOff drop from RUN, then glitch mid-warm-up
    set_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30, 1'b0, 32'h0);
    step("to_30");
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h50, 1'b0, 32'h0);
    step("kick_low");
    chk("kick_low_pc", pc, 32'h0);
    seq("rewarm0");
    seq("rewarm1");
    seq("rewarm2");
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("glitch");
    for (int i = 0; i < INIT + 1; i++) seq($sformatf("rewarm_full%0d", i));
    chk("rewarm_inited", {31'd0, inited}, 32'h1);
    seq("rerun4");

    // 6: asynchronous reset between edges
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_pc",   pc,                32'h0);
    chk("async_init", {31'd0, inited},   32'h0);
    chk("async_red",  {31'd0, redirect}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    seq("post_rst_warm");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
